// File: rtl/warp_fetch_scheduler.sv
// Round-robin warp fetch scheduler: per-warp PC/mask/state; one registered fetch per cycle.
// Launch/update reach fe_* two edges later; fe_* and the pointer hold while fe_valid_o && !ic_ready_i.
module warp_fetch_scheduler #(
   parameter int NumWarps  = 8,
   parameter int WarpWidth = 32,
   parameter int PcWidth   = 32,
   parameter int WidWidth  = $clog2(NumWarps)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_valid_i,
   output logic                 start_ready_o,
   input  logic [PcWidth-1:0]   start_pc_i,
   input  logic [WarpWidth-1:0] start_act_mask_i,
   output logic [WidWidth-1:0]  start_warp_id_o,
   input  logic                 ic_ready_i,
   output logic                 fe_valid_o,
   output logic [PcWidth-1:0]   fe_pc_o,
   output logic [WarpWidth-1:0] fe_act_mask_o,
   output logic [WidWidth-1:0]  fe_warp_id_o,
   input  logic                 upd_valid_i,
   input  logic [WidWidth-1:0]  upd_warp_id_i,
   input  logic [PcWidth-1:0]   upd_pc_i,
   input  logic [WarpWidth-1:0] upd_act_mask_i,
   input  logic                 upd_done_i,
   output logic [NumWarps-1:0]  warp_active_o
);
   localparam int IdxWidth = WidWidth + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_READY, ST_INFL} state_t;

   state_t               r_state [NumWarps];
   logic [PcWidth-1:0]   r_pc    [NumWarps];
   logic [WarpWidth-1:0] r_mask  [NumWarps];
   logic [WidWidth-1:0]  r_ptr;

   logic                 r_fe_vld;
   logic [PcWidth-1:0]   r_fe_pc;
   logic [WarpWidth-1:0] r_fe_mask;
   logic [WidWidth-1:0]  r_fe_wid;

   state_t               w_state_nxt [NumWarps];
   logic [PcWidth-1:0]   w_pc_nxt    [NumWarps];
   logic [WarpWidth-1:0] w_mask_nxt  [NumWarps];
   logic                 w_any_idle;
   logic [WidWidth-1:0]  w_start_wid;
   logic                 w_gnt_vld;
   logic [WidWidth-1:0]  w_gnt_wid;
   logic [IdxWidth-1:0]  w_idx;
   logic [WidWidth-1:0]  w_ptr_nxt;
   logic                 w_load;

   assign w_load = !r_fe_vld || ic_ready_i;

   // Round-robin search over READY warps starting at r_ptr.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_wid = '0;
      w_idx     = '0;
      for (int i = 0; i < NumWarps; i++) begin
         w_idx = {1'b0, r_ptr} + IdxWidth'(i);
         if (w_idx >= IdxWidth'(NumWarps)) begin
            w_idx = w_idx - IdxWidth'(NumWarps);
         end
         if (!w_gnt_vld && r_state[w_idx[WidWidth-1:0]] == ST_READY) begin
            w_gnt_vld = 1'b1;
            w_gnt_wid = w_idx[WidWidth-1:0];
         end
      end
      w_ptr_nxt = (w_gnt_wid == WidWidth'(NumWarps - 1)) ? '0 : w_gnt_wid + 1'b1;
   end

   // Warp state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int w = 0; w < NumWarps; w++) begin
            r_state[w] <= ST_IDLE;
            r_pc[w]    <= '0;
            r_mask[w]  <= '0;
         end
         r_ptr <= '0;
      end else begin
         for (int w = 0; w < NumWarps; w++) begin
            r_state[w] <= w_state_nxt[w];
            r_pc[w]    <= w_pc_nxt[w];
            r_mask[w]  <= w_mask_nxt[w];
         end
         if (w_load && w_gnt_vld) begin
            r_ptr <= w_ptr_nxt;
         end
      end
   end

   // Next state: launch targets an IDLE warp, grant a READY one, update an IN_FLIGHT one.
   always_comb begin
      for (int w = 0; w < NumWarps; w++) begin
         w_state_nxt[w] = r_state[w];
         w_pc_nxt[w]    = r_pc[w];
         w_mask_nxt[w]  = r_mask[w];
      end
      if (start_valid_i && w_any_idle && start_act_mask_i != '0) begin
         w_state_nxt[w_start_wid] = ST_READY;
         w_pc_nxt[w_start_wid]    = start_pc_i;
         w_mask_nxt[w_start_wid]  = start_act_mask_i;
      end
      if (w_load && w_gnt_vld) begin
         w_state_nxt[w_gnt_wid] = ST_INFL;
      end
      if (upd_valid_i && r_state[upd_warp_id_i] == ST_INFL) begin
         if (upd_done_i || upd_act_mask_i == '0) begin
            w_state_nxt[upd_warp_id_i] = ST_IDLE;
         end else begin
            w_state_nxt[upd_warp_id_i] = ST_READY;
            w_pc_nxt[upd_warp_id_i]    = upd_pc_i;
            w_mask_nxt[upd_warp_id_i]  = upd_act_mask_i;
         end
      end
   end

   // Outputs decoded from warp state.
   always_comb begin
      w_any_idle  = 1'b0;
      w_start_wid = '0;
      for (int w = NumWarps - 1; w >= 0; w--) begin
         warp_active_o[w] = (r_state[w] != ST_IDLE);
         if (r_state[w] == ST_IDLE) begin
            w_any_idle  = 1'b1;
            w_start_wid = WidWidth'(w);
         end
      end
   end

   assign start_ready_o   = w_any_idle;
   assign start_warp_id_o = w_start_wid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fe_vld  <= 1'b0;
         r_fe_pc   <= '0;
         r_fe_mask <= '0;
         r_fe_wid  <= '0;
      end else if (w_load) begin
         r_fe_vld <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_fe_pc   <= r_pc[w_gnt_wid];
            r_fe_mask <= r_mask[w_gnt_wid];
            r_fe_wid  <= w_gnt_wid;
         end
      end
   end

   assign fe_valid_o    = r_fe_vld;
   assign fe_pc_o       = r_fe_pc;
   assign fe_act_mask_o = r_fe_mask;
   assign fe_warp_id_o  = r_fe_wid;

endmodule
